arr_port_arbiter: RTL

// - Shares one single-port synchronous array RAM (write-enable/addr/wdata in, rdata one cycle later) between
//   N_REQ generated-datapath requesters and the host control port (override/debug path into the array).
// - Round-robin arbitration among datapath requesters; host takes exclusive ownership after a drain handshake.
// - Sits between the generated state-machine datapaths and the arr_* memory instance; the only driver of mem_*.

---
 rtl/arr_port_arbiter_if.sv | 37 +++
 rtl/arr_port_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/arr_port_arbiter_if.sv
// Bundle of requester, host and RAM-side signals around the array port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface arr_port_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;

    logic                    host_ctrl;
    logic                    host_ack;
    logic                    host_we;
    logic [ADDR_W-1:0]       host_addr;
    logic [DATA_W-1:0]       host_wdata;
    logic                    host_rvalid;

    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport slave (
        input  req, we, addr, wdata, host_ctrl, host_we, host_addr, host_wdata, mem_rdata,
        output gnt, rvalid, rdata, host_ack, host_rvalid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, host_ctrl, host_we, host_addr, host_wdata, mem_rdata,
        input  gnt, rvalid, rdata, host_ack, host_rvalid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arr_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between N_REQ datapath
// requesters and a host port that takes exclusive ownership after draining any pending read.
module arr_port_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arr_port_arbiter_if.slave    bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {ARB, DRAIN, HOST} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic               rd_pend_reg;
    logic               rd_host_reg;
    logic [IDX_W-1:0]   rd_id_reg;
    logic               host_ack_reg;

    logic [ADDR_W-1:0]  addr_slice  [N_REQ];
    logic [DATA_W-1:0]  wdata_slice [N_REQ];

    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   cand;
    logic               grant_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign addr_slice[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign wdata_slice[gi] = bus.wdata[gi*DATA_W +: DATA_W];
            assign bus.gnt[gi]     = grant_valid && (sel == IDX_W'(gi));
            assign bus.rvalid[gi]  = rst_n && rd_pend_reg && !rd_host_reg && (rd_id_reg == IDX_W'(gi));
        end
    endgenerate

    // Search upward from rr_ptr with wrap; the first set request wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        grant_valid = rst_n && (state_reg == ARB) && !bus.host_ctrl && found;
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rst_n && state_reg == HOST) begin
            bus.mem_we    = bus.host_we;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
        end else if (grant_valid) begin
            bus.mem_we    = bus.we[sel];
            bus.mem_addr  = addr_slice[sel];
            bus.mem_wdata = wdata_slice[sel];
        end
    end

    assign bus.rdata       = bus.mem_rdata;
    assign bus.host_ack    = host_ack_reg;
    assign bus.host_rvalid = rst_n && rd_pend_reg && rd_host_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ARB;
            rr_ptr_reg   <= '0;
            rd_pend_reg  <= 1'b0;
            rd_host_reg  <= 1'b0;
            rd_id_reg    <= '0;
            host_ack_reg <= 1'b0;
        end else begin
            rd_pend_reg <= 1'b0;
            case (state_reg)
                ARB: begin
                    if (bus.host_ctrl) begin
                        // A read issued last cycle still needs its data slot before the host may own the RAM.
                        state_reg    <= rd_pend_reg ? DRAIN : HOST;
                        host_ack_reg <= !rd_pend_reg;
                    end else if (grant_valid) begin
                        rr_ptr_reg <= (sel == IDX_W'(N_REQ-1)) ? '0 : sel + IDX_W'(1);
                        if (!bus.we[sel]) begin
                            rd_pend_reg <= 1'b1;
                            rd_host_reg <= 1'b0;
                            rd_id_reg   <= sel;
                        end
                    end
                end
                DRAIN: begin
                    state_reg    <= bus.host_ctrl ? HOST : ARB;
                    host_ack_reg <= bus.host_ctrl;
                end
                HOST: begin
                    if (!bus.host_we) begin
                        rd_pend_reg <= 1'b1;
                        rd_host_reg <= 1'b1;
                    end
                    if (!bus.host_ctrl) begin
                        state_reg    <= ARB;
                        host_ack_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ARB;
                    host_ack_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule
